// File: rtl/baud_pulse_gen.sv
// Baud-rate strobe generator: one-clock pulse every DIV clocks while enabled.
// DIV is CLK_FREQ/BAUD_RATE rounded to nearest; dropping en discards the phase.
module baud_pulse_gen #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic baud_pulse
);

  // Guard the divide so a zero rate reaches the parameter check below
  // instead of failing on a division by zero.
  localparam int DIV = (BAUD_RATE > 0) ? (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE : 2;
  localparam int CNT_W = ($clog2(DIV) > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  generate
    if (BAUD_RATE <= 0 || CLK_FREQ < 2 * BAUD_RATE || DIV < 2) begin : g_bad_params
      $error("baud_pulse_gen: invalid CLK_FREQ/BAUD_RATE combination");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_reg;
  logic             pulse_reg;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg   <= '0;
      pulse_reg <= 1'b1;
    end else begin
      cnt_reg   <= cnt_reg + 1'b1;
      pulse_reg <= 1'b0;
    end
  end

  assign baud_pulse = pulse_reg;

endmodule

// File: tb/tb_baud_pulse_gen.sv
// Self-checking bench for baud_pulse_gen: default rate (DIV=217) and a DIV=4 instance,
// each compared cycle by cycle against expected strobes queued when stimulus is driven.
module tb_baud_pulse_gen;

  localparam int DIV_A = 217;
  localparam int DIV_B = 4;

  logic clk;
  logic rst_a, en_a, pulse_a;
  logic rst_b, en_b, pulse_b;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int run_a    = 0;
  int run_b    = 0;
  int seen_a   = 0;
  string phase = "reset";

  logic exp_q_a[$];
  logic exp_q_b[$];

  baud_pulse_gen dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .en         (en_a),
    .baud_pulse (pulse_a)
  );

  baud_pulse_gen #(
    .CLK_FREQ  (1000),
    .BAUD_RATE (250)
  ) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .en         (en_b),
    .baud_pulse (pulse_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s (%s) edge %0d: got %0d, expected %0d", tag, phase, edge_n, obs, exp);
    end
  endtask

  // Expected output after an edge: high when the enabled run since the last
  // idle/reset edge has just completed a whole number of periods.
  task automatic tick(input logic ea, input logic ra, input logic eb, input logic rb);
    logic ea_exp, eb_exp, obs_a, obs_b;
    en_a  = ea;
    rst_a = ra;
    en_b  = eb;
    rst_b = rb;
    if (ra || !ea) run_a = 0; else run_a++;
    if (rb || !eb) run_b = 0; else run_b++;
    exp_q_a.push_back(run_a != 0 && (run_a % DIV_A) == 0);
    exp_q_b.push_back(run_b != 0 && (run_b % DIV_B) == 0);
    @(posedge clk);
    #1;
    edge_n++;
    ea_exp = exp_q_a.pop_front();
    eb_exp = exp_q_b.pop_front();
    obs_a  = pulse_a;
    obs_b  = pulse_b;
    check("pulse_a", int'(obs_a), int'(ea_exp));
    check("pulse_b", int'(obs_b), int'(eb_exp));
    if (obs_a) begin
      seen_a++;
      $display("edge %0d: dut_a pulse (%s)", edge_n, phase);
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;

    // Reset with en high to show rst wins.
    repeat (2) tick(1'b1, 1'b1, 1'b1, 1'b1);

    phase = "idle";
    seen_a = 0;
    repeat (500) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_pulse_count", seen_a, 0);

    phase = "run";
    seen_a = 0;
    repeat (2170) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("run_pulse_count", seen_a, 10);

    // Gap of 3 idle cycles at cnt=100, then a full period before the next pulse.
    phase = "en_gap";
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (100) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    seen_a = 0;
    repeat (216) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("gap_early_pulses", seen_a, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("gap_pulse_on_time", seen_a, 1);

    // One-edge reset at cnt=200 with en held high.
    phase = "mid_rst";
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (200) tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    seen_a = 0;
    repeat (216) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_early_pulses", seen_a, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_pulse_on_time", seen_a, 1);

    // en dropped on the edge where cnt == DIV-1 suppresses the pulse.
    phase = "a_drop_last";
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (216) tick(1'b1, 1'b0, 1'b0, 1'b0);
    seen_a = 0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("drop_last_no_pulse", seen_a, 0);

    phase = "b_pattern";
    repeat (12) tick(1'b0, 1'b0, 1'b1, 1'b0);
    phase = "b_drop_last";
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (9) tick(1'b0, 1'b0, 1'b1, 1'b0);
    phase = "b_mid_rst";
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b0, 1'b1, 1'b0);

    phase = "b_random";
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_pulse_gen.md
BAUD_PULSE_GEN -- requirements
Module: baud_pulse_gen

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, target pulse rate in Hz.
REQ-003 Derived constant DIV SHALL be (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE (integer, round-to-nearest); with the defaults DIV = 217.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  enable; 1 = generate pulses, 0 = idle and clear phase.
REQ-007 baud_pulse  output  1  one-clk-wide strobe, once per baud period, driven directly from a flip-flop.

Function
REQ-008 The block SHALL hold an internal counter cnt of width clog2(DIV), minimum 1 bit, counting 0..DIV-1.
REQ-009 Per rising edge with rst=0 and en=1: if cnt == DIV-1, then cnt <= 0 and baud_pulse <= 1; otherwise cnt <= cnt+1 and baud_pulse <= 0.
REQ-010 Per rising edge with rst=0 and en=0: cnt <= 0 and baud_pulse <= 0; the phase is fully discarded.
REQ-011 Latency: if en is first sampled high at edge E1 (cnt=0), baud_pulse SHALL be high only in the cycle following edge E_DIV, i.e. the first pulse is a full period after enable.
REQ-012 While en stays high, baud_pulse SHALL be high exactly 1 cycle in every DIV cycles, with period exactly DIV clocks and no drift.
REQ-013 Deasserting en for any number of cycles (>=1) and reasserting SHALL restart timing as in REQ-011.
REQ-014 If en falls in the same edge that cnt == DIV-1, no pulse SHALL be issued (en=0 has priority).
REQ-015 baud_pulse SHALL never be high for two consecutive cycles when DIV >= 2.
REQ-016 Elaboration SHALL fail (generate-time error) if BAUD_RATE == 0, CLK_FREQ < 2*BAUD_RATE, or DIV < 2.
REQ-017 The block SHALL contain no combinational path from any input to baud_pulse.

Reset
REQ-018 On any rising edge with rst=1: cnt <= 0 and baud_pulse <= 0, regardless of en; rst has priority over en.
REQ-019 Reset asserted mid-period SHALL discard the phase; after rst is released with en=1, the first pulse SHALL follow REQ-011 timing, counted from the first edge with rst=0.
REQ-020 Output state before the first reset edge is undefined; reset SHALL be held at least one clk edge.

Verification
REQ-021 Defaults, rst=1 for 2 edges, then rst=0 and en=0 for 500 cycles -> baud_pulse constantly 0.
REQ-022 Defaults, en=1 from edge E1 -> pulses after edges E217, E434 and E651; each pulse exactly 1 cycle wide; the count of pulses in 2170 cycles equals 10.
REQ-023 en=1, drop en at cnt=100 for 3 cycles, then reassert -> next pulse exactly 217 edges after reassertion, not earlier.
REQ-024 en=1, assert rst for 1 edge at cnt=200 while en stays 1 -> no pulse at the original slot; next pulse 217 edges after rst release.
REQ-025 Override CLK_FREQ=1000, BAUD_RATE=250 (DIV=4) -> pulse pattern 0,0,0,1 repeating; en dropped on the edge where cnt=3 -> no pulse.
REQ-026 Override BAUD_RATE > CLK_FREQ/2 -> elaboration error is reported.
